// File: rtl/led_mode_controller.sv
// led_mode_controller
//   Debounces a raw push-button and steps a four-state mode machine
//   (OFF -> SLOW -> FAST -> ON -> OFF) on each accepted press. The LED is
//   driven through a shared prescaler whose terminal count depends on the mode.
//
// Ports
//   clk    in   system clock, all state on the rising edge
//   rst    in   synchronous, active-high reset
//   key    in   raw asynchronous bouncing button, 1 = pressed
//   led    out  LED drive
//   mode   out  current mode: 0 OFF, 1 SLOW, 2 FAST, 3 ON
//   tick   out  one-cycle pulse on every LED toggle in SLOW/FAST
//   press  out  one-cycle pulse per accepted press
module led_mode_controller #(
  parameter int CNT_W           = 23,
  parameter int SLOW_DIV        = 8388608,
  parameter int FAST_DIV        = 2097152,
  parameter int DB_W            = 20,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key,
  output logic       led,
  output logic [1:0] mode,
  output logic       tick,
  output logic       press
);

  typedef enum logic [1:0] {
    MODE_OFF  = 2'd0,
    MODE_SLOW = 2'd1,
    MODE_FAST = 2'd2,
    MODE_ON   = 2'd3
  } mode_t;

  // Terminal counts are one below the divide ratio.
  localparam logic [CNT_W-1:0] SLOW_TC = CNT_W'(SLOW_DIV - 1);
  localparam logic [CNT_W-1:0] FAST_TC = CNT_W'(FAST_DIV - 1);
  localparam logic [DB_W-1:0]  DB_TC   = DB_W'(DEBOUNCE_CYCLES - 1);

  logic             key_s1_reg;
  logic             key_s2_reg;
  logic             key_db_reg;
  logic             key_db_prev_reg;
  logic [DB_W-1:0]  db_cnt_reg;
  logic             press_reg;
  logic             press_next;

  mode_t            state_reg;
  mode_t            state_next;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;
  logic [CNT_W-1:0] tc;
  logic             led_reg;
  logic             led_next;
  logic             tick_reg;
  logic             tick_next;

  // Two-flop synchroniser followed by the debouncer. Any reversal of key_s2
  // against the accepted level restarts the stability count from zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      key_s1_reg      <= 1'b0;
      key_s2_reg      <= 1'b0;
      key_db_reg      <= 1'b0;
      key_db_prev_reg <= 1'b0;
      db_cnt_reg      <= '0;
      press_reg       <= 1'b0;
    end else begin
      key_s1_reg      <= key;
      key_s2_reg      <= key_s1_reg;
      key_db_prev_reg <= key_db_reg;
      press_reg       <= press_next;
      if (key_s2_reg == key_db_reg) begin
        db_cnt_reg <= '0;
      end else if (db_cnt_reg == DB_TC) begin
        key_db_reg <= key_s2_reg;
        db_cnt_reg <= '0;
      end else begin
        db_cnt_reg <= db_cnt_reg + DB_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= MODE_OFF;
      cnt_reg   <= '0;
      led_reg   <= 1'b0;
      tick_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      led_reg   <= led_next;
      tick_reg  <= tick_next;
    end
  end

  always_comb begin
    // Rising edge of the debounced key only; releases are ignored.
    press_next = key_db_reg & ~key_db_prev_reg;
    state_next = state_reg;
    cnt_next   = cnt_reg;
    led_next   = led_reg;
    tick_next  = 1'b0;
    tc         = (state_reg == MODE_SLOW) ? SLOW_TC : FAST_TC;

    if (press_next) begin
      // A mode change overrides a coincident terminal count, so every blink
      // mode starts dark with a full period.
      case (state_reg)
        MODE_OFF:  state_next = MODE_SLOW;
        MODE_SLOW: state_next = MODE_FAST;
        MODE_FAST: state_next = MODE_ON;
        default:   state_next = MODE_OFF;
      endcase
      cnt_next = '0;
      led_next = (state_next == MODE_ON);
    end else begin
      case (state_reg)
        MODE_OFF: begin
          cnt_next = '0;
          led_next = 1'b0;
        end
        MODE_ON: begin
          cnt_next = '0;
          led_next = 1'b1;
        end
        default: begin
          if (cnt_reg == tc) begin
            cnt_next  = '0;
            led_next  = ~led_reg;
            tick_next = 1'b1;
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end
      endcase
    end
  end

  assign led   = led_reg;
  assign mode  = state_reg;
  assign tick  = tick_reg;
  assign press = press_reg;

endmodule
